// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp patterns for the intersection phase scheduler.
package traffic_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LAMP_W  = 6;

  typedef enum logic [PHASE_W-1:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    WALK   = 3'd5,
    RED_B  = 3'd6
  } state_e;

  // Lamp bus: [5:3] main {G,Y,R}, [2:0] side {G,Y,R}
  localparam logic [LAMP_W-1:0] L_MAIN_G = 6'b100001;
  localparam logic [LAMP_W-1:0] L_MAIN_Y = 6'b010001;
  localparam logic [LAMP_W-1:0] L_ALL_R  = 6'b001001;
  localparam logic [LAMP_W-1:0] L_SIDE_G = 6'b001100;
  localparam logic [LAMP_W-1:0] L_SIDE_Y = 6'b001010;

  function automatic logic [LAMP_W-1:0] lamp_of(input state_e s);
    case (s)
      MAIN_G:  lamp_of = L_MAIN_G;
      MAIN_Y:  lamp_of = L_MAIN_Y;
      SIDE_G:  lamp_of = L_SIDE_G;
      SIDE_Y:  lamp_of = L_SIDE_Y;
      default: lamp_of = L_ALL_R;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_sched_tick_gen.sv
// Restartable clock divider: one-cycle tick every TICK_DIV clocks, counted
// from the most recent clr.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // tick depends only on the count so clr may be derived from it without a loop
  assign tick = (cnt_q == DIV_LAST);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Intersection phase scheduler: main road rests green, side-road vehicle and
// pedestrian requests are latched and served round-robin.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MAIN_MIN = 4,
  parameter int unsigned YEL_T    = 1,
  parameter int unsigned RED_T    = 1,
  parameter int unsigned SIDE_T   = 2,
  parameter int unsigned SIDE_EXT = 2,
  parameter int unsigned WALK_T   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 side_req,
  input  logic                 ped_req,
  input  logic                 ext_sw,
  output logic [LAMP_W-1:0]    light,
  output logic                 walk,
  output logic [PHASE_W-1:0]   phase
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAIN_LAST  = CNT_W'(MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] MAIN_SAT   = CNT_W'(MAIN_MIN);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST  = CNT_W'(SIDE_T - 1);
  localparam logic [CNT_W-1:0] SIDEX_LAST = CNT_W'(SIDE_T + SIDE_EXT - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_T - 1);

  logic side_s1_q, side_s2_q;
  logic ped_s1_q, ped_s2_q, ped_s3_q;
  logic ext_s1_q, ext_s2_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic               side_pend_q, side_pend_d;
  logic               ped_pend_q, ped_pend_d;
  logic               rr_q, rr_d;
  logic               ext_q, ext_d;
  logic [LAMP_W-1:0]  light_q, light_d;
  logic               walk_q, walk_d;

  logic               tick;
  logic               entry_c;
  logic               ped_edge_c;
  logic [CNT_W-1:0]   side_last_c;

  assign ped_edge_c  = ped_s2_q & ~ped_s3_q;
  assign side_last_c = ext_q ? SIDEX_LAST : SIDE_LAST;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry_c),
    .tick (tick)
  );

  // Next state, tick count, request bookkeeping and decoded lamps
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    side_pend_d = side_pend_q | (side_s2_q && (state_q != SIDE_G));
    ped_pend_d  = ped_pend_q | (ped_edge_c && (state_q != WALK));
    rr_d        = rr_q;
    ext_d       = ext_q;

    case (state_q)
      MAIN_G: begin
        if (tick && (tcnt_q >= MAIN_LAST) && (side_pend_q || ped_pend_q)) begin
          state_d = MAIN_Y;
        end
      end
      MAIN_Y: if (tick && (tcnt_q == YEL_LAST)) state_d = RED_A;
      RED_A: begin
        if (tick && (tcnt_q == RED_LAST)) begin
          if (side_pend_q && ped_pend_q) state_d = rr_q ? WALK : SIDE_G;
          else if (side_pend_q)          state_d = SIDE_G;
          else if (ped_pend_q)           state_d = WALK;
          else                           state_d = RED_B;
        end
      end
      SIDE_G: if (tick && (tcnt_q == side_last_c)) state_d = SIDE_Y;
      SIDE_Y: if (tick && (tcnt_q == YEL_LAST))    state_d = RED_B;
      WALK:   if (tick && (tcnt_q == WALK_LAST))   state_d = RED_B;
      RED_B:  if (tick && (tcnt_q == RED_LAST))    state_d = MAIN_G;
      default: state_d = RED_B;
    endcase

    entry_c = (state_d != state_q);

    // Main green count saturates so a resting main road can exit on any later tick
    if (entry_c) begin
      tcnt_d = '0;
    end else if (tick && !((state_q == MAIN_G) && (tcnt_q >= MAIN_SAT))) begin
      tcnt_d = tcnt_q + CNT_W'(1);
    end

    if (entry_c && (state_d == SIDE_G)) begin
      side_pend_d = 1'b0;
      rr_d        = 1'b1;
      ext_d       = ext_s2_q;
    end
    if (entry_c && (state_d == WALK)) begin
      ped_pend_d = 1'b0;
      rr_d       = 1'b0;
    end

    light_d = lamp_of(state_d);
    walk_d  = (state_d == WALK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      side_s1_q   <= 1'b0;
      side_s2_q   <= 1'b0;
      ped_s1_q    <= 1'b0;
      ped_s2_q    <= 1'b0;
      ped_s3_q    <= 1'b0;
      ext_s1_q    <= 1'b0;
      ext_s2_q    <= 1'b0;
      state_q     <= MAIN_G;
      tcnt_q      <= '0;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      rr_q        <= 1'b0;
      ext_q       <= 1'b0;
      light_q     <= L_MAIN_G;
      walk_q      <= 1'b0;
    end else begin
      side_s1_q   <= side_req;
      side_s2_q   <= side_s1_q;
      ped_s1_q    <= ped_req;
      ped_s2_q    <= ped_s1_q;
      ped_s3_q    <= ped_s2_q;
      ext_s1_q    <= ext_sw;
      ext_s2_q    <= ext_s1_q;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      rr_q        <= rr_d;
      ext_q       <= ext_d;
      light_q     <= light_d;
      walk_q      <= walk_d;
    end
  end

  assign light = light_q;
  assign walk  = walk_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench: stimulus queues the expected phase segments (lamps, walk,
// phase code, length in clocks); a monitor checks each segment as it closes.
module tb_traffic_phase_sched;

  typedef struct {
    logic [5:0] light;
    logic       walk;
    logic [2:0] phase;
    int         cycles;
  } seg_t;

  localparam logic [5:0] LG  = 6'b100001;
  localparam logic [5:0] LY  = 6'b010001;
  localparam logic [5:0] LR  = 6'b001001;
  localparam logic [5:0] LSG = 6'b001100;
  localparam logic [5:0] LSY = 6'b001010;

  logic       clk;
  logic       rst;
  logic       side_req;
  logic       ped_req;
  logic       ext_sw;
  logic [5:0] light;
  logic       walk;
  logic [2:0] phase;

  int   tests = 0;
  int   fails = 0;
  seg_t exp_q[$];

  traffic_phase_sched #(
    .TICK_DIV (4),
    .MAIN_MIN (3),
    .YEL_T    (1),
    .RED_T    (1),
    .SIDE_T   (2),
    .SIDE_EXT (2),
    .WALK_T   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .side_req (side_req),
    .ped_req  (ped_req),
    .ext_sw   (ext_sw),
    .light    (light),
    .walk     (walk),
    .phase    (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_seg(input logic [5:0] l, input logic w, input logic [2:0] p, input int n);
    seg_t s;
    s.light  = l;
    s.walk   = w;
    s.phase  = p;
    s.cycles = n;
    exp_q.push_back(s);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_out(input string name, input logic [5:0] l, input logic w, input logic [2:0] p);
    tests++;
    if (light !== l || walk !== w || phase !== p) begin
      fails++;
      $display("FAIL %s: got light=%b walk=%b phase=%0d, expected light=%b walk=%b phase=%0d",
               name, light, walk, phase, l, w, p);
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d expected segments still unobserved, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // Reset with the given input levels held, release between clock edges
  task automatic start(input logic side, input logic ped, input logic ext, input string name);
    rst      = 1'b1;
    side_req = side;
    ped_req  = ped;
    ext_sw   = ext;
    wait_edges(1);
    check_out(name, LG, 1'b0, 3'd0);
    wait_edges(2);
    rst = 1'b0;
  endtask

  // Monitor: a segment closes when {light,walk,phase} changes
  initial begin : monitor
    logic [9:0] obs;
    logic [9:0] cur;
    int         run_len;
    seg_t       e;
    cur     = '0;
    run_len = 0;
    forever begin
      @(negedge clk);
      obs = {light, walk, phase};
      if (rst) begin
        cur     = obs;
        run_len = 0;
      end else if (obs != cur) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got light=%b walk=%b phase=%0d after %0d cycles, expected no change",
                   cur[9:4], cur[3], cur[2:0], run_len);
        end else begin
          e = exp_q.pop_front();
          if (cur[9:4] !== e.light || cur[3] !== e.walk || cur[2:0] !== e.phase || run_len != e.cycles) begin
            fails++;
            $display("FAIL segment: got light=%b walk=%b phase=%0d cycles=%0d, expected light=%b walk=%b phase=%0d cycles=%0d",
                     cur[9:4], cur[3], cur[2:0], run_len, e.light, e.walk, e.phase, e.cycles);
          end
        end
        cur     = obs;
        run_len = 1;
      end else begin
        run_len++;
      end
    end
  end

  initial begin : stimulus
    rst      = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;
    ext_sw   = 1'b0;

    // Idle: main green rests indefinitely
    start(1'b0, 1'b0, 1'b0, "reset_idle");
    wait_edges(200);
    check_out("idle_rest", LG, 1'b0, 3'd0);
    check_drained("idle_drained");

    // Side request from reset release, no extension
    start(1'b1, 1'b0, 1'b0, "reset_side");
    expect_seg(LG,  1'b0, 3'd0, 12);
    expect_seg(LY,  1'b0, 3'd1, 4);
    expect_seg(LR,  1'b0, 3'd2, 4);
    expect_seg(LSG, 1'b0, 3'd3, 8);
    expect_seg(LSY, 1'b0, 3'd4, 4);
    expect_seg(LR,  1'b0, 3'd6, 4);
    wait_edges(22);
    side_req = 1'b0;
    wait_edges(28);
    check_out("side_back_to_main", LG, 1'b0, 3'd0);
    check_drained("side_drained");

    // Extension latched at side-green entry; later switch change ignored
    start(1'b1, 1'b0, 1'b1, "reset_ext");
    expect_seg(LG,  1'b0, 3'd0, 12);
    expect_seg(LY,  1'b0, 3'd1, 4);
    expect_seg(LR,  1'b0, 3'd2, 4);
    expect_seg(LSG, 1'b0, 3'd3, 16);
    expect_seg(LSY, 1'b0, 3'd4, 4);
    expect_seg(LR,  1'b0, 3'd6, 4);
    wait_edges(22);
    side_req = 1'b0;
    wait_edges(2);
    ext_sw = 1'b0;
    wait_edges(36);
    check_drained("ext_drained");

    // Pedestrian pulse while resting: exit at the next tick boundary
    start(1'b0, 1'b0, 1'b0, "reset_ped");
    expect_seg(LG, 1'b0, 3'd0, 24);
    expect_seg(LY, 1'b0, 3'd1, 4);
    expect_seg(LR, 1'b0, 3'd2, 4);
    expect_seg(LR, 1'b1, 3'd5, 12);
    expect_seg(LR, 1'b0, 3'd6, 4);
    wait_edges(20);
    ped_req = 1'b1;
    wait_edges(1);
    ped_req = 1'b0;
    wait_edges(39);
    check_drained("ped_drained");

    // Both requests: side first, walk after next main green, then side first again
    start(1'b0, 1'b0, 1'b0, "reset_both");
    expect_seg(LG,  1'b0, 3'd0, 12);
    expect_seg(LY,  1'b0, 3'd1, 4);
    expect_seg(LR,  1'b0, 3'd2, 4);
    expect_seg(LSG, 1'b0, 3'd3, 8);
    expect_seg(LSY, 1'b0, 3'd4, 4);
    expect_seg(LR,  1'b0, 3'd6, 4);
    expect_seg(LG,  1'b0, 3'd0, 12);
    expect_seg(LY,  1'b0, 3'd1, 4);
    expect_seg(LR,  1'b0, 3'd2, 4);
    expect_seg(LR,  1'b1, 3'd5, 12);
    expect_seg(LR,  1'b0, 3'd6, 4);
    expect_seg(LG,  1'b0, 3'd0, 12);
    expect_seg(LY,  1'b0, 3'd1, 4);
    expect_seg(LR,  1'b0, 3'd2, 4);
    expect_seg(LSG, 1'b0, 3'd3, 8);
    wait_edges(2);
    side_req = 1'b1;
    ped_req  = 1'b1;
    wait_edges(2);
    side_req = 1'b0;
    ped_req  = 1'b0;
    wait_edges(76);
    side_req = 1'b1;
    ped_req  = 1'b1;
    wait_edges(2);
    side_req = 1'b0;
    ped_req  = 1'b0;
    wait_edges(20);
    check_out("rr_second_side", LSY, 1'b0, 3'd4);
    check_drained("both_drained");

    // Reset mid side-green with pedestrian pending
    start(1'b0, 1'b0, 1'b0, "reset_pre_abort");
    expect_seg(LG, 1'b0, 3'd0, 12);
    expect_seg(LY, 1'b0, 3'd1, 4);
    expect_seg(LR, 1'b0, 3'd2, 4);
    wait_edges(2);
    side_req = 1'b1;
    ped_req  = 1'b1;
    wait_edges(2);
    side_req = 1'b0;
    ped_req  = 1'b0;
    wait_edges(20);
    check_out("pre_abort_side_g", LSG, 1'b0, 3'd3);
    rst = 1'b1;
    #1;
    check_out("async_reset_mid_side_g", LG, 1'b0, 3'd0);
    wait_edges(2);
    rst = 1'b0;
    wait_edges(100);
    check_out("no_walk_after_reset", LG, 1'b0, 3'd0);
    check_drained("abort_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

- Intersection phase scheduler that decides which movement owns the crossing: main road, side road, or pedestrian crosswalk.
- Sequences main green, yellow, all-red, side green and walk phases from a one-second (parameterised) tick.
- Latches side-road vehicle and pedestrian requests, arbitrates between them round-robin, and drives the 6-bit lamp bus plus walk lamp.
- Sits between the board buttons/switches and the LED outputs, replacing a fixed-cycle light sequencer.

## Interface
- TICK_DIV, 100000000: clk cycles per timing tick.
- MAIN_MIN, 4: minimum main-green ticks.
- YEL_T, 1: yellow ticks.
- RED_T, 1: all-red ticks.
- SIDE_T, 2: side-green ticks.
- SIDE_EXT, 2: extra side-green ticks when extended.
- WALK_T, 3: walk ticks.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- side_req  in  1  async side-road vehicle sensor, level.
- ped_req  in  1  async pedestrian button, level.
- ext_sw  in  1  async side-green extension switch.
- light  out  6  [5:3] main {G,Y,R}, [2:0] side {G,Y,R}; registered.
- walk  out  1  pedestrian walk lamp; registered.
- phase  out  3  current state encoding; registered.

## Operation
- Input conditioning: all three inputs use 2-flop synchronizers. ped_req is rising-edge detected after sync. side_req and ext_sw are used as levels.
- Pending flags:
  - side_pend sets on synced side_req high. It does not set while in SIDE_G.
  - ped_pend sets on a ped edge. It does not set while in WALK.
  - A flag clears on the cycle its serving phase is entered. If set and clear coincide, clear wins.
- rr flag: 0 means side has priority. It toggles to point away from whichever request was just served. Reset value is 0.
- States, with light/walk decoded from state:
  - MAIN_G: light 100001.
    - Stays at least MAIN_MIN ticks.
    - After that, exits to MAIN_Y on the first tick boundary where side_pend or ped_pend is set.
    - With nothing pending it rests indefinitely; the tick counter saturates at MAIN_MIN.
  - MAIN_Y: light 010001, YEL_T ticks, then RED_A.
  - RED_A: light 001001, RED_T ticks. At exit:
    - both pending: go to SIDE_G if rr=0, else WALK;
    - only one pending: go to that one;
    - none pending (impossible by construction): go to RED_B.
  - SIDE_G: light 001100.
    - Duration is SIDE_T, or SIDE_T+SIDE_EXT if synced ext_sw=1 on the entry cycle.
    - ext_sw changes after entry are ignored.
    - Next state: SIDE_Y.
  - SIDE_Y: light 001010, YEL_T ticks, then RED_B.
  - WALK: light 001001, walk=1, WALK_T ticks, then RED_B.
  - RED_B: light 001001, RED_T ticks, then MAIN_G.
- A request left unserved by arbitration stays pending and is served on the next cycle after MAIN_MIN expires.
- Illegal phase encodings go to RED_B on the next clk.

## Timing
- Reset (asynchronous) sets:
  - state MAIN_G, phase 0;
  - light 100001, walk 0;
  - pending flags 0, rr 0;
  - tick divider 0, tick counter 0; synchronizer flops 0.
- Tick divider:
  - restarts on every state entry, so a phase of N ticks lasts exactly N×TICK_DIV clk cycles;
  - tick is a 1-cycle pulse on divider count TICK_DIV-1.
- Transition: on the clk edge where tick=1 and tick count = duration-1. light, walk and phase update on that same edge (outputs derived from next state).
- Request latency: side_req high to side_pend set takes 3 clk edges (2 sync + latch). A request arriving in the final cycle of MAIN_G's minimum is seen at the following tick.
- Widths:
  - divider is $clog2(TICK_DIV) bits;
  - tick counter is 8 bits, and every duration parameter must be ≤255 and ≥1.

## Structure
- Package traffic_pkg holds:
  - state localparams MAIN_G=0, MAIN_Y=1, RED_A=2, SIDE_G=3, SIDE_Y=4, WALK=5, RED_B=6;
  - lamp constants L_MAIN_G=6'b100001, L_MAIN_Y=6'b010001, L_ALL_R=6'b001001, L_SIDE_G=6'b001100, L_SIDE_Y=6'b001010.
- Sub-module tick_gen (inputs clk, rst, clr; output tick): the restartable divider.
- The scheduler FSM, synchronizers, pending flags and arbiter stay in the top module.

## Test plan
All scenarios use TICK_DIV=4, MAIN_MIN=3, YEL_T=1, RED_T=1, SIDE_T=2, SIDE_EXT=2, WALK_T=3.
- No requests for 200 cycles after reset → light stays 100001, walk 0, phase 0.
- side_req held high from reset release, ext_sw=0 → the following sequence, then back to 100001:

  | Phase | light | cycles |
  |---|---|---|
  | MAIN_G | 100001 | 12 |
  | MAIN_Y | 010001 | 4 |
  | RED_A | 001001 | 4 |
  | SIDE_G | 001100 | 8 |
  | SIDE_Y | 001010 | 4 |
  | RED_B | 001001 | 4 |

- Same stimulus with ext_sw=1 before SIDE_G entry, toggled to 0 mid-phase → SIDE_G lasts 16 cycles.
- ped_req 1-cycle pulse at cycle 20 while resting in MAIN_G → MAIN_Y at the next tick boundary, then RED_A, then WALK with walk=1 for 12 cycles, then RED_B, then MAIN_G.
- side_req and ped_req both asserted in MAIN_G → side served first (rr=0). Ped stays pending, WALK follows after the next 12-cycle MAIN_G, and rr=0 again afterwards.
- rst asserted mid-SIDE_G with ped pending → outputs immediately 100001/walk 0/phase 0, pending cleared, no WALK without a new request.
